iiitb_dmem_arb: RTL and testbench

Two-port arbiter that shares the single data memory (32 × 32-bit words) between the pipeline's MEM stage and an external debug/loader port. Fixed priority goes to the core, and a starvation counter bounds how long the debug port can wait. The block drives the memory's one access port, returns read data with a fixed latency, and raises a stall to the pipeline when the core loses arbitration.

---
 rtl/iiitb_pkg.sv | 29 ++
 rtl/iiitb_dmem_arb_if.sv | 68 ++++++
 rtl/iiitb_dmem_arb.sv | 142 ++++++++++++++
 tb/tb_iiitb_dmem_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/iiitb_pkg.sv
// iiitb_pkg - shared types and constants for the data-memory arbiter.
//
// Contents:
//   DMEM_AW / DMEM_DW - data memory word-address and data widths
//   port_e            - which requester owns a transfer (core or debug)
//   arb_state_e       - arbiter FSM states (LOCK only reachable with
//                       DMEM_ARB_LOCK_EN defined)
//   rd_owner_t        - {valid, port} tag for an in-flight read
package iiitb_pkg;

  localparam int DMEM_AW = 5;
  localparam int DMEM_DW = 32;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_DBG  = 1'b1
  } port_e;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } rd_owner_t;

endpackage

// File: rtl/iiitb_dmem_arb_if.sv
// iiitb_dmem_arb_if - bus bundle between the core MEM stage, the debug
// loader, the data memory and the arbiter.
//
// Signals:
//   c_*  : core request (req/we/addr/wdata) and response (gnt/rvalid/rdata),
//          plus core_stall
//   d_*  : debug request and response; d_lock only with DMEM_ARB_LOCK_EN
//   m_*  : single memory access port (en/we/addr/wdata out, rdata in)
//
// Modports:
//   slave  - the arbiter side
//   master - the requester / memory side (used by environments and benches)
interface iiitb_dmem_arb_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  logic          core_stall;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
`ifdef DMEM_ARB_LOCK_EN
  logic          d_lock;
`endif

  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata, core_stall,
    input  d_req, d_we, d_addr, d_wdata,
`ifdef DMEM_ARB_LOCK_EN
    input  d_lock,
`endif
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata, core_stall,
    output d_req, d_we, d_addr, d_wdata,
`ifdef DMEM_ARB_LOCK_EN
    output d_lock,
`endif
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata
  );

endinterface

// File: rtl/iiitb_dmem_arb.sv
// iiitb_dmem_arb - two-port arbiter for the single-ported data memory.
//
// The core (MEM stage) has fixed priority; the debug/loader port wins once it
// has lost STARVE_MAX consecutive cycles. Grants are combinational in the
// request cycle, the transfer happens on the following rising edge, and read
// data comes back one cycle later tagged to the port that issued it.
//
// Ports:
//   clk  - clock, all state on the rising edge
//   RN   - synchronous active-high reset; while high every grant, rvalid,
//          stall and memory strobe is forced low and data outputs are 0
//   bus  - iiitb_dmem_arb_if.slave: core port, debug port, memory port
//
// Parameters: AW (word address width), DW (data width), STARVE_MAX (1..15).
// AW/DW must match the parameters of the connected interface instance.
//
// Optional feature: define DMEM_ARB_LOCK_EN to add bus.d_lock. A debug grant
// with d_lock high enters LOCK, where only debug may be granted; the first
// cycle with d_lock low arbitrates normally again.
module iiitb_dmem_arb
  import iiitb_pkg::*;
#(
  parameter int AW         = DMEM_AW,
  parameter int DW         = DMEM_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                RN,
  iiitb_dmem_arb_if.slave     bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt_reg, starve_cnt_next;
  arb_state_e state_reg, state_next;
  rd_owner_t  rd_owner_reg, rd_owner_next;

  logic          c_gnt;
  logic          d_gnt;
  logic          lock_active;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          c_rvalid;
  logic          d_rvalid;

  // Arbitration, memory mux and next-state logic.
  always_comb begin
    c_gnt           = 1'b0;
    d_gnt           = 1'b0;
    lock_active     = 1'b0;
    m_en            = 1'b0;
    m_we            = 1'b0;
    m_addr          = '0;
    m_wdata         = '0;
    starve_cnt_next = starve_cnt_reg;
    state_next      = state_reg;
    rd_owner_next   = '{valid: 1'b0, port: PORT_CORE};

`ifdef DMEM_ARB_LOCK_EN
    // Lock only holds while d_lock stays high; the release cycle already
    // arbitrates normally so the core can win immediately.
    lock_active = (state_reg == LOCK) && bus.d_lock;
`endif

    if (!RN) begin
      if (lock_active) begin
        d_gnt = bus.d_req;
      end else begin
        // A lone core request always wins; against a debug request it wins
        // only while debug has not yet been starved.
        c_gnt = bus.c_req && (!bus.d_req || (starve_cnt_reg < STARVE_LIM));
        d_gnt = bus.d_req && !c_gnt;
      end
    end

    if (c_gnt) begin
      m_en    = 1'b1;
      m_we    = bus.c_we;
      m_addr  = bus.c_addr;
      m_wdata = bus.c_wdata;
    end else if (d_gnt) begin
      m_en    = 1'b1;
      m_we    = bus.d_we;
      m_addr  = bus.d_addr;
      m_wdata = bus.d_wdata;
    end

    if (!bus.d_req || d_gnt) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt_reg < STARVE_LIM) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    if (m_en && !m_we) begin
      rd_owner_next.valid = 1'b1;
      rd_owner_next.port  = d_gnt ? PORT_DBG : PORT_CORE;
    end

`ifdef DMEM_ARB_LOCK_EN
    case (state_reg)
      ARB:     if (d_gnt && bus.d_lock) state_next = LOCK;
      LOCK:    if (!bus.d_lock) state_next = ARB;
      default: state_next = ARB;
    endcase
    if (state_reg == LOCK) begin
      starve_cnt_next = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (RN) begin
      starve_cnt_reg <= 4'd0;
      state_reg      <= ARB;
      rd_owner_reg   <= '{valid: 1'b0, port: PORT_CORE};
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      state_reg      <= state_next;
      rd_owner_reg   <= rd_owner_next;
    end
  end

  // Read return: the memory's registered output is steered to the port that
  // owned the read issued last cycle; the other port sees zero.
  assign c_rvalid = !RN && rd_owner_reg.valid && (rd_owner_reg.port == PORT_CORE);
  assign d_rvalid = !RN && rd_owner_reg.valid && (rd_owner_reg.port == PORT_DBG);

  assign bus.c_gnt      = c_gnt;
  assign bus.d_gnt      = d_gnt;
  assign bus.core_stall = !RN && bus.c_req && !c_gnt;
  assign bus.c_rvalid   = c_rvalid;
  assign bus.d_rvalid   = d_rvalid;
  assign bus.c_rdata    = c_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata    = d_rvalid ? bus.m_rdata : '0;
  assign bus.m_en       = m_en;
  assign bus.m_we       = m_we;
  assign bus.m_addr     = m_addr;
  assign bus.m_wdata    = m_wdata;

endmodule

// File: tb/tb_iiitb_dmem_arb.sv
// tb_iiitb_dmem_arb - directed, table-driven bench for iiitb_dmem_arb with a
// small write-first memory model (registered read) on the memory port.
// Each vector is one clock cycle: inputs driven at the falling edge, outputs
// compared 1 ns later. Expected values are hand-computed for STARVE_MAX = 4.
module tb_iiitb_dmem_arb;
  import iiitb_pkg::*;

  localparam logic [31:0] W1 = 32'h1111_1111;
  localparam logic [31:0] W2 = 32'h2222_2222;
  localparam logic [31:0] W3 = 32'h0000_0042;
  localparam logic [31:0] WB = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rn  = 1'b1;
  always #5 clk = ~clk;

  iiitb_dmem_arb_if #(.AW(DMEM_AW), .DW(DMEM_DW)) bus ();

  iiitb_dmem_arb #(.AW(DMEM_AW), .DW(DMEM_DW), .STARVE_MAX(4)) dut (
    .clk (clk),
    .RN  (rn),
    .bus (bus)
  );

  // Memory model: reloaded with known contents whenever reset is high.
  logic [31:0] mem [32];
  always @(posedge clk) begin
    if (rn) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1] <= W1;
      mem[2] <= W2;
      mem[3] <= W3;
      bus.m_rdata <= 32'h0;
    end else if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr];
    end
  end

  typedef struct {
    logic        rn;
    logic        c_req, c_we;
    logic [4:0]  c_addr;
    logic [31:0] c_wdata;
    logic        d_req, d_we;
    logic [4:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_cg, e_dg, e_st, e_men, e_mwe;
    logic [4:0]  e_maddr;
    logic [31:0] e_mwdata;
    logic        e_crv;
    logic [31:0] e_crd;
    logic        e_drv;
    logic [31:0] e_drd;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  function automatic vec_t mkv(
    logic rn_i, logic cr, logic cw, logic [4:0] ca, logic [31:0] cd,
    logic dr, logic dw, logic [4:0] da, logic [31:0] dd,
    logic ecg, logic edg, logic est, logic emen, logic emwe,
    logic [4:0] emaddr, logic [31:0] emwdata,
    logic ecrv, logic [31:0] ecrd, logic edrv, logic [31:0] edrd);
    vec_t v;
    v.rn = rn_i; v.c_req = cr; v.c_we = cw; v.c_addr = ca; v.c_wdata = cd;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
    v.e_cg = ecg; v.e_dg = edg; v.e_st = est; v.e_men = emen; v.e_mwe = emwe;
    v.e_maddr = emaddr; v.e_mwdata = emwdata;
    v.e_crv = ecrv; v.e_crd = ecrd; v.e_drv = edrv; v.e_drd = edrd;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(vec_t v, int idx, logic lk = 1'b0);
    @(negedge clk);
    rn          = v.rn;
    bus.c_req   = v.c_req;
    bus.c_we    = v.c_we;
    bus.c_addr  = v.c_addr;
    bus.c_wdata = v.c_wdata;
    bus.d_req   = v.d_req;
    bus.d_we    = v.d_we;
    bus.d_addr  = v.d_addr;
    bus.d_wdata = v.d_wdata;
`ifdef DMEM_ARB_LOCK_EN
    bus.d_lock  = lk;
`else
    if (lk) $display("note: vec %0d requests d_lock, feature not built", idx);
`endif
    #1;
    chk("c_gnt",      idx, 32'(bus.c_gnt),      32'(v.e_cg));
    chk("d_gnt",      idx, 32'(bus.d_gnt),      32'(v.e_dg));
    chk("core_stall", idx, 32'(bus.core_stall), 32'(v.e_st));
    chk("m_en",       idx, 32'(bus.m_en),       32'(v.e_men));
    chk("m_we",       idx, 32'(bus.m_we),       32'(v.e_mwe));
    chk("m_addr",     idx, 32'(bus.m_addr),     32'(v.e_maddr));
    chk("m_wdata",    idx, bus.m_wdata,         v.e_mwdata);
    chk("c_rvalid",   idx, 32'(bus.c_rvalid),   32'(v.e_crv));
    chk("c_rdata",    idx, bus.c_rdata,         v.e_crd);
    chk("d_rvalid",   idx, 32'(bus.d_rvalid),   32'(v.e_drv));
    chk("d_rdata",    idx, bus.d_rdata,         v.e_drd);
    $display("vec %0d: rn=%b c_req=%b d_req=%b -> c_gnt=%b d_gnt=%b stall=%b m_en=%b c_rv=%b c_rd=%h d_rv=%b d_rd=%h",
             idx, rn, bus.c_req, bus.d_req, bus.c_gnt, bus.d_gnt, bus.core_stall,
             bus.m_en, bus.c_rvalid, bus.c_rdata, bus.d_rvalid, bus.d_rdata);
  endtask

  vec_t tbl [20];
  vec_t cont_c, cont_d, cont_cr, cont_cd, idle, idle_drv;

  initial begin
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
    bus.d_lock = 1'b0;
`endif
    repeat (3) @(posedge clk);

    // Contention patterns: core reads addr 3, debug reads addr 2.
    cont_c   = mkv(0, 1,0,3,0, 1,0,2,0, 1,0,0,1,0,3,0, 0,0,  0,0);
    cont_cr  = mkv(0, 1,0,3,0, 1,0,2,0, 1,0,0,1,0,3,0, 1,W3, 0,0);
    cont_d   = mkv(0, 1,0,3,0, 1,0,2,0, 0,1,1,1,0,2,0, 1,W3, 0,0);
    cont_cd  = mkv(0, 1,0,3,0, 1,0,2,0, 1,0,0,1,0,3,0, 0,0,  1,W2);
    idle     = mkv(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 0,0,  0,0);
    idle_drv = mkv(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 0,0,  1,W2);

    // Reset dominates live requests.
    tbl[0]  = mkv(1, 1,0,3,0, 1,0,2,0, 0,0,0,0,0,0,0, 0,0, 0,0);
    // Core-only read of addr 3.
    tbl[1]  = mkv(0, 1,0,3,0, 0,0,0,0, 1,0,0,1,0,3,0, 0,0, 0,0);
    tbl[2]  = mkv(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 1,W3, 0,0);
    // Debug write to addr 7, then core read of addr 7.
    tbl[3]  = mkv(0, 0,0,0,0, 1,1,7,WB, 0,1,0,1,1,7,WB, 0,0, 0,0);
    tbl[4]  = mkv(0, 1,0,7,0, 0,0,0,0, 1,0,0,1,0,7,0, 0,0, 0,0);
    tbl[5]  = mkv(0, 0,0,0,0, 0,0,0,0, 0,0,0,0,0,0,0, 1,WB, 0,0);
    // Back-to-back: core reads 1, debug reads 2.
    tbl[6]  = mkv(0, 1,0,1,0, 0,0,0,0, 1,0,0,1,0,1,0, 0,0, 0,0);
    tbl[7]  = mkv(0, 0,0,0,0, 1,0,2,0, 0,1,0,1,0,2,0, 1,W1, 0,0);
    tbl[8]  = idle_drv;
    // Ten cycles of contention: core x4, debug, core x4, debug.
    tbl[9]  = cont_c;
    tbl[10] = cont_cr;
    tbl[11] = cont_cr;
    tbl[12] = cont_cr;
    tbl[13] = cont_d;
    tbl[14] = cont_cd;
    tbl[15] = cont_cr;
    tbl[16] = cont_cr;
    tbl[17] = cont_cr;
    tbl[18] = cont_d;
    tbl[19] = idle_drv;

    for (int i = 0; i < 20; i++) apply(tbl[i], i);

    // Reset mid-operation: the counter has climbed to 2 and a core read was
    // granted the cycle before reset. No rvalid may follow, and afterwards the
    // core must again win four contended cycles before debug gets one.
    apply(cont_c, 100);
    apply(cont_cr, 101);
    apply(mkv(1, 1,0,3,0, 1,0,2,0, 0,0,0,0,0,0,0, 0,0, 0,0), 102);
    apply(cont_c, 103);
    apply(cont_cr, 104);
    apply(cont_cr, 105);
    apply(cont_cr, 106);
    apply(cont_d, 107);
    apply(idle_drv, 108);
    apply(idle, 109);

`ifdef DMEM_ARB_LOCK_EN
    // Lock: one locked debug write with core idle enters LOCK, then three
    // locked writes while the core waits, then the core wins on release.
    apply(mkv(0, 0,0,0,0, 1,1,10,32'hA, 0,1,0,1,1,10,32'hA, 0,0, 0,0), 200, 1'b1);
    apply(mkv(0, 1,0,3,0, 1,1,11,32'hB, 0,1,1,1,1,11,32'hB, 0,0, 0,0), 201, 1'b1);
    apply(mkv(0, 1,0,3,0, 1,1,12,32'hC, 0,1,1,1,1,12,32'hC, 0,0, 0,0), 202, 1'b1);
    apply(mkv(0, 1,0,3,0, 1,1,13,32'hD, 0,1,1,1,1,13,32'hD, 0,0, 0,0), 203, 1'b1);
    apply(mkv(0, 1,0,3,0, 0,0,0,0,     1,0,0,1,0,3,0,      0,0, 0,0), 204, 1'b0);
    apply(mkv(0, 1,0,13,0, 0,0,0,0,    1,0,0,1,0,13,0,     1,W3, 0,0), 205, 1'b0);
    apply(mkv(0, 0,0,0,0, 0,0,0,0,     0,0,0,0,0,0,0,      1,32'hD, 0,0), 206, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
